// File: rtl/hangman_pkg.sv
// Shared letter codes and game state encoding for the Hangman controller.
package hangman_pkg;

    localparam logic [5:0] LETTER_A  = 6'h0A;
    localparam logic [5:0] LETTER_Z  = 6'h23;
    localparam logic [5:0] BLANK     = 6'h3F;
    localparam int         NUM_CODES = 26;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_GUESS,
        CHECK,
        WIN,
        LOSE
    } state_t;

endpackage

// File: rtl/hangman_match.sv
// Combinational compare of one guessed letter against the four word positions.
module hangman_match
    import hangman_pkg::*;
#(
    parameter int LETTER_W = 6
) (
    input  logic [LETTER_W-1:0] guess,
    input  logic [LETTER_W-1:0] letter1,
    input  logic [LETTER_W-1:0] letter2,
    input  logic [LETTER_W-1:0] letter3,
    input  logic [LETTER_W-1:0] letter4,
    output logic [3:0]          match,
    output logic                valid_code
);

    assign match = {guess == letter4, guess == letter3,
                    guess == letter2, guess == letter1};

    assign valid_code = (guess >= LETTER_W'(LETTER_A)) &&
                        (guess <= LETTER_W'(LETTER_Z));

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: latches a word, scores guesses, tracks lives and win/lose.
module hangman_game_ctrl
    import hangman_pkg::*;
#(
    parameter int NUM_LIVES = 6,
    parameter int LETTER_W  = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [LETTER_W-1:0] letter1,
    input  logic [LETTER_W-1:0] letter2,
    input  logic [LETTER_W-1:0] letter3,
    input  logic [LETTER_W-1:0] letter4,
    input  logic                guess_valid,
    input  logic [LETTER_W-1:0] guess,
    output logic                guess_ready,
    output logic [3:0]          revealed,
    output logic [3:0]          lives_left,
    output logic [LETTER_W-1:0] disp1,
    output logic [LETTER_W-1:0] disp2,
    output logic [LETTER_W-1:0] disp3,
    output logic [LETTER_W-1:0] disp4,
    output logic                repeat_guess,
    output logic                guess_err,
    output logic                busy,
    output logic                win,
    output logic                lose
);

    localparam logic [LETTER_W-1:0] BLANK_W = LETTER_W'(BLANK);

    state_t                  state;
    logic [LETTER_W-1:0]     word1, word2, word3, word4;
    logic [LETTER_W-1:0]     guess_q;
    logic [NUM_CODES-1:0]    guessed;

    logic [3:0]              match;
    logic                    valid_code;
    logic [LETTER_W-1:0]     code_off;
    logic [NUM_CODES-1:0]    guess_bit;
    logic                    already;
    logic [3:0]              lives_dec;
    state_t                  check_next;

    hangman_match #(.LETTER_W(LETTER_W)) u_match (
        .guess      (guess_q),
        .letter1    (word1),
        .letter2    (word2),
        .letter3    (word3),
        .letter4    (word4),
        .match      (match),
        .valid_code (valid_code)
    );

    // {busy, guess_ready, win, lose} as seen while sitting in state s
    function automatic logic [3:0] flags_of(input state_t s);
        return {(s == LOAD) || (s == WAIT_GUESS) || (s == CHECK),
                s == WAIT_GUESS, s == WIN, s == LOSE};
    endfunction

    always_comb begin
        code_off   = guess_q - LETTER_W'(LETTER_A);
        guess_bit  = NUM_CODES'(1) << code_off;
        already    = |(guessed & guess_bit);
        lives_dec  = (lives_left == 4'd0) ? 4'd0 : lives_left - 4'd1;
        check_next = WAIT_GUESS;
        if (valid_code && !already) begin
            if (|match) begin
                if ((revealed | match) == 4'hF)
                    check_next = WIN;
            end else if (lives_dec == 4'd0) begin
                check_next = LOSE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            word1        <= '0;
            word2        <= '0;
            word3        <= '0;
            word4        <= '0;
            guess_q      <= '0;
            guessed      <= '0;
            revealed     <= 4'd0;
            lives_left   <= 4'(NUM_LIVES);
            repeat_guess <= 1'b0;
            guess_err    <= 1'b0;
            {busy, guess_ready, win, lose} <= 4'b0000;
        end else begin
            repeat_guess <= 1'b0;
            guess_err    <= 1'b0;
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state <= LOAD;
                        {busy, guess_ready, win, lose} <= flags_of(LOAD);
                    end
                end
                LOAD: begin
                    word1      <= letter1;
                    word2      <= letter2;
                    word3      <= letter3;
                    word4      <= letter4;
                    revealed   <= 4'd0;
                    guessed    <= '0;
                    lives_left <= 4'(NUM_LIVES);
                    state      <= WAIT_GUESS;
                    {busy, guess_ready, win, lose} <= flags_of(WAIT_GUESS);
                end
                WAIT_GUESS: begin
                    if (guess_valid) begin
                        guess_q <= guess;
                        state   <= CHECK;
                        {busy, guess_ready, win, lose} <= flags_of(CHECK);
                    end
                end
                CHECK: begin
                    if (!valid_code) begin
                        guess_err <= 1'b1;
                    end else if (already) begin
                        repeat_guess <= 1'b1;
                    end else begin
                        guessed <= guessed | guess_bit;
                        if (|match)
                            revealed <= revealed | match;
                        else
                            lives_left <= lives_dec;
                    end
                    state <= check_next;
                    {busy, guess_ready, win, lose} <= flags_of(check_next);
                end
                default: begin
                    state <= IDLE;
                    {busy, guess_ready, win, lose} <= flags_of(IDLE);
                end
            endcase
        end
    end

    // A losing board exposes the whole word
    assign disp1 = (revealed[0] || state == LOSE) ? word1 : BLANK_W;
    assign disp2 = (revealed[1] || state == LOSE) ? word2 : BLANK_W;
    assign disp3 = (revealed[2] || state == LOSE) ? word3 : BLANK_W;
    assign disp4 = (revealed[3] || state == LOSE) ? word4 : BLANK_W;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Scoreboard bench for hangman_game_ctrl: directed game plan plus random games vs a rule model.
module tb_hangman_game_ctrl;

    localparam int NL = 6;
    localparam int LW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] letter1, letter2, letter3, letter4;
    logic          guess_valid;
    logic [LW-1:0] guess;
    logic          guess_ready;
    logic [3:0]    revealed;
    logic [3:0]    lives_left;
    logic [LW-1:0] disp1, disp2, disp3, disp4;
    logic          repeat_guess, guess_err, busy, win, lose;

    hangman_game_ctrl #(.NUM_LIVES(NL), .LETTER_W(LW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .letter1      (letter1),
        .letter2      (letter2),
        .letter3      (letter3),
        .letter4      (letter4),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ready  (guess_ready),
        .revealed     (revealed),
        .lives_left   (lives_left),
        .disp1        (disp1),
        .disp2        (disp2),
        .disp3        (disp3),
        .disp4        (disp4),
        .repeat_guess (repeat_guess),
        .guess_err    (guess_err),
        .busy         (busy),
        .win          (win),
        .lose         (lose)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [37:0] v;
        bit          chk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Rule-level model of one game
    logic [5:0] m_word[4];
    bit         m_guessed[26];
    bit [3:0]   m_rev;
    int         m_lives;
    int         m_phase;   // 0 idle, 1 playing, 2 game over

    function automatic logic [37:0] act_vec();
        return {revealed, lives_left, repeat_guess, guess_err, win, lose,
                guess_ready, busy, disp4, disp3, disp2, disp1};
    endfunction

    function automatic logic [37:0] pack_exp(input bit rep, input bit err);
        logic [5:0] d[4];
        bit         mw, ml, rdy;
        mw  = (m_phase == 2) && (m_rev == 4'hF);
        ml  = (m_phase == 2) && (m_lives == 0);
        rdy = (m_phase == 1);
        for (int i = 0; i < 4; i++)
            d[i] = (m_rev[i] || ml) ? m_word[i] : 6'h3F;
        return {m_rev, 4'(m_lives), rep, err, mw, ml, rdy, rdy,
                d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [37:0] model_guess(input logic [5:0] code);
        bit rep, err, hit;
        int idx;
        rep = 0; err = 0; hit = 0;
        if (code < 6'h0A || code > 6'h23) begin
            err = 1;
        end else begin
            idx = int'(code) - 10;
            if (m_guessed[idx]) begin
                rep = 1;
            end else begin
                m_guessed[idx] = 1;
                for (int i = 0; i < 4; i++)
                    if (m_word[i] == code) begin
                        m_rev[i] = 1'b1;
                        hit = 1;
                    end
                if (!hit && m_lives > 0)
                    m_lives--;
            end
        end
        if (m_rev == 4'hF || m_lives == 0)
            m_phase = 2;
        return pack_exp(rep, err);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_word[i] = 6'h00;
        for (int i = 0; i < 26; i++) m_guessed[i] = 0;
        m_rev   = 4'h0;
        m_lives = NL;
        m_phase = 0;
    endtask

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_word(input logic [5:0] a, input logic [5:0] b,
                            input logic [5:0] c, input logic [5:0] d);
        letter1 = a; letter2 = b; letter3 = c; letter4 = d;
    endtask

    task automatic do_start();
        start = 1'b1;
        if (m_phase != 1) begin
            model_reset();
            m_word[0] = letter1; m_word[1] = letter2;
            m_word[2] = letter3; m_word[3] = letter4;
            m_phase = 1;
        end
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic do_guess(input logic [5:0] g, input bit hold2, input bit with_start);
        int n;
        n = 0;
        while (!guess_ready && n < 20) begin
            tick();
            n++;
        end
        if (!guess_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=0 expected=1");
            return;
        end
        // The randomizer keeps changing; the latched word must not follow it
        set_word(6'($urandom_range(10, 35)), 6'($urandom_range(10, 35)),
                 6'($urandom_range(10, 35)), 6'($urandom_range(10, 35)));
        guess       = g;
        guess_valid = 1'b1;
        start       = with_start;
        q.push_back('{model_guess(g), 1'b1});
        tick();
        start = 1'b0;
        if (hold2)
            guess = (g == 6'h23) ? 6'h0A : g + 6'd1;
        else
            guess_valid = 1'b0;
        tick();
        guess_valid = 1'b0;
        tick();
    endtask

    // Monitor: an accepted guess produces its result two falling edges later
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && guess_ready && guess_valid) begin
                @(negedge clock);
                @(negedge clock);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty actual=result expected=none");
                end else begin
                    e = q.pop_front();
                    if (e.chk) check("guess_result", act_vec(), e.v);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [5:0] g;
        reset = 1'b1; start = 1'b0; guess_valid = 1'b0; guess = '0;
        set_word(6'h00, 6'h00, 6'h00, 6'h00);
        model_reset();
        #12;
        check("reset_state", act_vec(), pack_exp(0, 0));
        reset = 1'b0;
        tick();

        // HEAD
        set_word(6'h11, 6'h0E, 6'h0A, 6'h0D);
        do_start();
        check("start_head", act_vec(), pack_exp(0, 0));
        do_guess(6'h0E, 0, 0);
        check("disp_head_e", {disp4, disp3, disp2, disp1}, {6'h3F, 6'h3F, 6'h0E, 6'h3F});
        do_guess(6'h0E, 0, 0);
        do_start();
        check("start_ignored", act_vec(), pack_exp(0, 0));
        do_guess(6'h1B, 0, 0);
        do_guess(6'h0C, 0, 1);
        do_guess(6'h05, 0, 0);
        do_guess(6'h30, 0, 0);
        do_guess(6'h11, 1, 0);
        check("drop_in_check", act_vec(), pack_exp(0, 0));

        // Reset while a guess is in CHECK
        guess = 6'h0A; guess_valid = 1'b1;
        q.push_back('{38'h0, 1'b0});
        tick();
        guess_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_mid_check", act_vec(), pack_exp(0, 0));
        tick();
        reset = 1'b0;
        tick();

        // DARN, clean win
        set_word(6'h0D, 6'h0A, 6'h1B, 6'h17);
        do_start();
        do_guess(6'h0D, 0, 0);
        do_guess(6'h0A, 0, 0);
        do_guess(6'h1B, 0, 0);
        do_guess(6'h17, 0, 0);
        tick();
        check("win_hold", act_vec(), pack_exp(0, 0));

        // LIFE, six misses
        set_word(6'h15, 6'h12, 6'h0F, 6'h0E);
        do_start();
        do_guess(6'h0B, 0, 0);
        do_guess(6'h0C, 0, 0);
        do_guess(6'h10, 0, 0);
        do_guess(6'h13, 0, 0);
        do_guess(6'h14, 0, 0);
        do_guess(6'h16, 0, 0);
        tick();
        check("lose_hold", act_vec(), pack_exp(0, 0));
        check("lose_disp", {disp4, disp3, disp2, disp1}, {6'h0E, 6'h0F, 6'h12, 6'h15});
        do_start();
        check("restart_after_lose", act_vec(), pack_exp(0, 0));

        // Random games
        for (int game = 0; game < 20; game++) begin
            if (m_phase == 1) begin
                cnt = 0;
                while (m_phase == 1 && cnt < 80) begin
                    do_guess(6'($urandom_range(10, 35)), 0, 0);
                    cnt++;
                end
            end
            set_word(6'($urandom_range(10, 35)), 6'($urandom_range(10, 35)),
                     6'($urandom_range(10, 35)), 6'($urandom_range(10, 35)));
            do_start();
            check("random_start", act_vec(), pack_exp(0, 0));
            cnt = 0;
            while (m_phase == 1 && cnt < 80) begin
                if ($urandom_range(0, 7) == 0)
                    g = 6'($urandom_range(0, 63));
                else
                    g = 6'($urandom_range(10, 35));
                do_guess(g, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
                cnt++;
            end
        end

        tick();
        tick();
        check("queue_drained", 38'(q.size()), 38'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hangman_game_ctrl.md
Name: hangman_game_ctrl

Overview:
Game-sequencing controller for the Hangman datapath. On start it latches the current 4-letter word from the randomizer. It then accepts guessed letter codes one at a time, reveals matching positions, counts down lives and flags win or lose. It sits between the randomizer, the guess input logic (keypad or switch capture) and the HEX/display driver.

Parameters:
NUM_LIVES, 6, misses allowed before LOSE (1..15)
LETTER_W, 6, letter code width (codes 6'h0A='A' .. 6'h23='Z')

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  pulse; begins a new game (honoured in IDLE, WIN, LOSE only)
letter1..letter4  in  LETTER_W each  current randomizer word, positions 1..4
guess_valid  in  1  guess offered this cycle
guess  in  LETTER_W  guessed letter code
guess_ready  out  1  high only in WAIT_GUESS
revealed  out  4  bit i-1 set = position i uncovered
lives_left  out  4  remaining lives
disp1..disp4  out  LETTER_W each  latched letter if revealed (or in LOSE), else BLANK 6'h3F
repeat_guess  out  1  one-cycle pulse: letter already guessed
guess_err  out  1  one-cycle pulse: code outside 6'h0A..6'h23
busy  out  1  high in LOAD, WAIT_GUESS, CHECK
win  out  1  high in WIN
lose  out  1  high in LOSE

Behaviour:
- Reset, async, takes effect immediately: state=IDLE; word regs=0; revealed=0; lives_left=NUM_LIVES; guessed-set (26 bits)=0; all pulses, win, lose, busy and guess_ready=0; disp*=BLANK.
- IDLE: start -> LOAD.
- LOAD, 1 cycle: latch letter1..4; clear revealed and guessed-set; lives_left=NUM_LIVES; -> WAIT_GUESS.
- WAIT_GUESS: guess_ready=1. A guess is accepted when guess_valid=1; latch the guess; -> CHECK. guess_valid while not ready is dropped, not queued.
- CHECK, 1 cycle; all results are visible the cycle after CHECK:
  - Invalid code: guess_err pulse; nothing else changes.
  - Bit already in guessed-set: repeat_guess pulse; lives unchanged.
  - Otherwise set the guessed-set bit (index = code-6'h0A).
    - Hit (matches at least one position): OR all matching positions into revealed; duplicate letters reveal together.
    - Miss: lives_left decrements by 1.
  - Next state: revealed==4'hF -> WIN; lives_left==0 -> LOSE; else WAIT_GUESS. A hit never costs a life, so WIN and LOSE cannot coincide.
- WIN/LOSE: hold outputs; in LOSE, disp* show all four letters. start -> LOAD.
- start in LOAD, WAIT_GUESS or CHECK: ignored. Start and guess_valid in the same WAIT_GUESS cycle: the guess is taken.
- lives_left saturates at 0. The word is stable for the whole game regardless of the randomizer input.
- Latency: guess accepted at edge N; revealed, lives_left and pulses update at edge N+1; guess_ready returns at N+1 unless the game ended.

Decomposition:
- hangman_pkg holds:
  - LETTER_A=6'h0A, LETTER_Z=6'h23, BLANK=6'h3F
  - state enum {IDLE, LOAD, WAIT_GUESS, CHECK, WIN, LOSE}
- Sub-module hangman_match: combinational; guess and 4 letters in; 4-bit match vector plus valid_code out. Instantiated once.

Test Plan:
- Word HEAD (11,0E,0A,0D), start, guess 0E -> revealed=4'b0010, lives=6, disp2=0E, others 3F.
- Same game, guess 0E again -> repeat_guess pulse, revealed and lives unchanged; guess 1B -> lives=5.
- Word DARN (0D,0A,1B,17), guesses 0D,0A,1B,17 with no misses -> revealed=4'hF, win=1, busy=0, guess_ready=0.
- Six distinct misses (0B,0C,10,13,14,16) against LIFE -> lives=0, lose=1, disp1..4=15,12,0F,0E; then start -> LOAD, lives=6.
- Guess 6'h05 and 6'h30 -> guess_err each, no state change; guess_valid asserted in CHECK -> dropped.
- Assert reset mid-CHECK -> immediate IDLE, revealed=0, lives=6, disp*=3F; randomizer word change mid-game -> disp unaffected.
